// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Load/store port between the CPU MEM stage (master) and the data memory
//   responder (slave).
//
//   Handshake: the master raises req_i together with we_i/addr_i/data_i. A
//   request is accepted on a rising edge where both req_i and ready_o are 1.
//   After that edge ready_o stays low until the transaction has finished. The
//   responder then pulses ack_o high for exactly one cycle. data_o and err_o
//   are valid only while ack_o is 1. A new request is never accepted in an
//   ack_o cycle.
//
//   Signals:
//     req_i   - request valid
//     we_i    - 1 = write, 0 = read
//     addr_i  - byte address
//     data_i  - write data
//     ready_o - responder can accept a request this cycle
//     ack_o   - one-cycle completion strobe
//     data_o  - read data (0 on write acknowledges)
//     err_o   - completion carries an error
interface data_mem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        ack_o;
  logic [31:0] data_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, data_i,
    input  ready_o, ack_o, data_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, data_i,
    output ready_o, ack_o, data_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-wide data memory that responds to the CPU load/store port. It accepts
//   one read or write, waits LATENCY cycles, and then returns a one-cycle
//   acknowledge that carries the read data. All outputs are registered.
//
//   Parameters:
//     DEPTH_WORDS - number of 32-bit words (power of two, >= 2)
//     LATENCY     - cycles spent in WAIT after acceptance (1..15)
//
//   Ports:
//     clk_i     - clock, rising edge
//     rst_i     - asynchronous, active-low reset
//     bus       - load/store port (slave modport of data_mem_responder_if)
//     dbg_state - current FSM state, for observation only
//
//   Optional feature, enabled by defining DATA_MEM_ALIGN_CHECK_EN:
//     An access whose byte address has addr[1:0] != 0 completes with
//     err_o = 1 and data_o = 0, and its write is suppressed. When the macro
//     is not defined, addr[1:0] is ignored and err_o is always 0.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  data_mem_responder_if.slave   bus,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic              ack_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              misaligned;
  logic              commit;

  // Storage is deliberately left without a reset.
  logic [31:0]       mem [DEPTH_WORDS];

  // Address bits above the index select nothing: out-of-range addresses wrap.
`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic              misaligned_q;
  logic              unused_addr;
  assign unused_addr = ^bus.addr_i[31:IDX_W+2];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      misaligned_q <= 1'b0;
    end else if (state == IDLE && bus.req_i) begin
      misaligned_q <= (bus.addr_i[1:0] != 2'b00);
    end
  end

  assign misaligned = misaligned_q;
`else
  logic              unused_addr;
  assign unused_addr = ^{bus.addr_i[31:IDX_W+2], bus.addr_i[1:0]};
  assign misaligned  = 1'b0;
`endif

  // The access completes on the edge that leaves WAIT.
  assign commit = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            we_q    <= bus.we_i;
            idx_q   <= bus.addr_i[IDX_W+1:2];
            wdata_q <= bus.data_i;
            cnt     <= 4'(LATENCY - 1);
            ready_q <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Writes and rejected accesses return zero data.
            rdata_q <= (we_q || misaligned) ? 32'd0 : mem[idx_q];
            err_q   <= misaligned;
            ack_q   <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Reset forces state to IDLE asynchronously, so an aborted write never
  // reaches this commit condition.
  always_ff @(posedge clk_i) begin
    if (commit && we_q && !misaligned) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.ack_o   = ack_q;
  assign bus.data_o  = rdata_q;
  assign bus.err_o   = err_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_cyc_q[$];
  int          last_ack = -1;
  int          prev_ack = -1;
  int          acc_cyc  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i && bus.ack_o === 1'b1) begin
      check("ready_low_at_ack", 32'(bus.ready_o), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        logic        ee;
        int          ec;
        e  = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("ack_data", bus.data_o, e);
        check("ack_err", 32'(bus.err_o), 32'(ee));
        check("ack_cycle", 32'(cyc), 32'(ec));
      end
      prev_ack = last_ack;
      last_ack = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_data, input logic exp_err,
                           input bit hold, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    bus.req_i  = 1'b1;
    bus.we_i   = we;
    bus.addr_i = addr;
    bus.data_i = data;
    @(posedge clk);
    acc_cyc = cyc;
    if (track) begin
      exp_q.push_back(exp_data);
      exp_err_q.push_back(exp_err);
      exp_cyc_q.push_back(cyc + LAT + 1);
    end
    #1;
    if (!hold) bus.req_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_err);
    start_txn(1'b1, addr, data, 32'd0, exp_err, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err);
    start_txn(1'b0, addr, 32'd0, exp_data, exp_err, 1'b0, 1'b1);
    wait_drain();
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] model [8];
  int          a1;
  int          a2;

  initial begin
    bus.req_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'd0;
    bus.data_i = 32'd0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_data", bus.data_o, 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    rst_i = 1'b1;

    // Write then read
    do_write(32'h10, 32'hDEADBEEF, 1'b0);
    do_read(32'h10, 32'hDEADBEEF, 1'b0);

    // Wrap: 0x400 is word 256, i.e. word 0
    do_write(32'h400, 32'h12345678, 1'b0);
    do_read(32'h000, 32'h12345678, 1'b0);

    // Back-to-back reads with req held high
    do_write(32'h4, 32'h0BADF00D, 1'b0);
    start_txn(1'b0, 32'h0, 32'd0, 32'h12345678, 1'b0, 1'b1, 1'b1);
    a1 = acc_cyc;
    start_txn(1'b0, 32'h4, 32'd0, 32'h0BADF00D, 1'b0, 1'b0, 1'b1);
    a2 = acc_cyc;
    check("b2b_accept_gap", 32'(a2 - a1), 32'(LAT + 2));
    wait_drain();
    check("b2b_ack_gap", 32'(last_ack - prev_ack), 32'(LAT + 2));

    // Reset abort during WAIT
    do_write(32'h20, 32'h00000000, 1'b0);
    start_txn(1'b1, 32'h20, 32'hAAAAAAAA, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus.ready_o), 32'd1);
    check("abort_ack", 32'(bus.ack_o), 32'd0);
    rst_i = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    do_read(32'h20, 32'h00000000, 1'b0);

    // Misaligned write to 0x22
`ifdef DATA_MEM_ALIGN_CHECK_EN
    do_write(32'h22, 32'hCAFEF00D, 1'b1);
    do_read(32'h20, 32'h00000000, 1'b0);
    do_read(32'h23, 32'h00000000, 1'b1);
`else
    do_write(32'h22, 32'hCAFEF00D, 1'b0);
    do_read(32'h20, 32'hCAFEF00D, 1'b0);
    do_read(32'h23, 32'hCAFEF00D, 1'b0);
`endif

    // Random data through a small model
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      do_write(32'h100 + 32'(i * 4), model[i], 1'b0);
    end
    for (int i = 7; i >= 0; i--) begin
      start_txn(1'b0, 32'h100 + 32'(i * 4), 32'd0, model[i], 1'b0,
                1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    repeat (LAT + 3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
